// File: rtl/hcsr04_emulador_pkg.sv
// hcsr04_emulador_pkg
//   Shared definitions for the HC-SR04 emulator: 4-bit state codes (also shown
//   on the db_estado debug output), default timing constants for a 50 MHz
//   clock, and small elaboration-time helpers for counter sizing.
//   No ports.
package hcsr04_emulador_pkg;

   // State codes; these exact values appear on db_estado
   localparam logic [3:0] INICIAL = 4'd0;
   localparam logic [3:0] TRIGGER = 4'd1;
   localparam logic [3:0] RAJADA  = 4'd2;
   localparam logic [3:0] ECO     = 4'd3;
   localparam logic [3:0] ESPERA  = 4'd4;

   // Default timing at 50 MHz
   localparam int TRIG_MIN_CYC_DEF = 500;      // 10 us
   localparam int BURST_CYC_DEF    = 10000;    // 200 us
   localparam int CYC_PER_CM_DEF   = 2941;     // 58.82 us/cm
   localparam int DIST_MIN_CM_DEF  = 2;
   localparam int DIST_MAX_CM_DEF  = 400;
   localparam int TIMEOUT_CYC_DEF  = 1900000;  // 38 ms
   localparam int HOLDOFF_CYC_DEF  = 500000;   // 10 ms

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Bits needed for a counter running 0..m-1 (at least one bit)
   function automatic int cnt_width(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/hcsr04_emulador_contador_m.sv
// hcsr04_emulador_contador_m
//   Mod-M up counter with synchronous clear. Counts 0..M-1 and wraps.
//   Ports:
//     clock  in   system clock
//     reset  in   synchronous active-high reset (q -> 0)
//     zera   in   synchronous clear, has priority over conta
//     conta  in   count enable
//     q      out  current count, cnt_width(M) bits
//     fim    out  high while q == M-1 (terminal count)
module hcsr04_emulador_contador_m
   import hcsr04_emulador_pkg::*;
#(
   parameter int M = 10
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    zera,
   input  logic                    conta,
   output logic [cnt_width(M)-1:0] q,
   output logic                    fim
);

   localparam int            W   = cnt_width(M);
   localparam logic [W-1:0]  ULT = W'(M - 1);

   assign fim = (q == ULT);

   always_ff @(posedge clock) begin
      if (reset)      q <= '0;
      else if (zera)  q <= '0;
      else if (conta) q <= fim ? '0 : q + 1'b1;
   end

endmodule

// File: rtl/hcsr04_emulador.sv
// hcsr04_emulador
//   HC-SR04 ultrasonic sensor emulator (responder side of trigger/echo).
//   A synchronized trigger pulse of at least TRIG_MIN_CYC cycles latches
//   distancia_cm on its falling edge; after BURST_CYC cycles echo is driven
//   high for distancia_cm*CYC_PER_CM cycles, followed by HOLDOFF_CYC cycles
//   of dead time during which triggers are ignored.
//   Configuration macro HCSR04_EMU_TIMEOUT_EN: when defined, an out-of-range
//   distance produces an echo of TIMEOUT_CYC cycles; when undefined, it skips
//   straight to the dead time with no echo.
//   Ports:
//     clock         in   system clock
//     reset         in   synchronous active-high reset
//     trigger       in   trigger request, asynchronous to clock
//     distancia_cm  in   emulated distance in cm (unsigned, 9 bits)
//     echo          out  echo pulse, registered
//     ocupado       out  high whenever the FSM is not in INICIAL
//     db_estado     out  current state code for debug display
module hcsr04_emulador
   import hcsr04_emulador_pkg::*;
#(
   parameter int TRIG_MIN_CYC = TRIG_MIN_CYC_DEF,
   parameter int BURST_CYC    = BURST_CYC_DEF,
   parameter int CYC_PER_CM   = CYC_PER_CM_DEF,
   parameter int DIST_MIN_CM  = DIST_MIN_CM_DEF,
   parameter int DIST_MAX_CM  = DIST_MAX_CM_DEF,
   parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
   parameter int HOLDOFF_CYC  = HOLDOFF_CYC_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       trigger,
   input  logic [8:0] distancia_cm,
   output logic       echo,
   output logic       ocupado,
   output logic [3:0] db_estado
);

   // The trigger counter saturates at TRIG_MIN_CYC, so it needs one extra state
   localparam int TRG_M = TRIG_MIN_CYC + 1;

   // One timer serves burst, hold-off and (optionally) the timeout echo
`ifdef HCSR04_EMU_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
   localparam int TMR_M      = max_int(max_int(BURST_CYC, HOLDOFF_CYC), TIMEOUT_CYC);
`else
   localparam bit TIMEOUT_EN = 1'b0;
   localparam int TMR_M      = max_int(BURST_CYC, HOLDOFF_CYC);
   localparam int UNUSED_TIMEOUT = TIMEOUT_CYC;
`endif
   localparam int TW = cnt_width(TMR_M);

   localparam logic [TW-1:0] BURST_ULT = TW'(BURST_CYC - 1);
   localparam logic [TW-1:0] HOLD_ULT  = TW'(HOLDOFF_CYC - 1);
`ifdef HCSR04_EMU_TIMEOUT_EN
   localparam logic [TW-1:0] TOUT_ULT  = TW'(TIMEOUT_CYC - 1);
`endif
   localparam logic [8:0]    D_MIN     = 9'(DIST_MIN_CM);
   localparam logic [8:0]    D_MAX     = 9'(DIST_MAX_CM);

   logic                       trig_m, trig_s;
   logic [3:0]                 estado, prox;
   logic [8:0]                 dist_r;
   logic [8:0]                 cm_cnt;
   logic                       em_faixa, fim_eco;

   logic [cnt_width(TRG_M)-1:0]      trg_q;
   logic                             trg_fim, trg_zera, trg_conta;
   logic [TW-1:0]                    tmr_q;
   logic                             tmr_fim, tmr_zera, tmr_conta;
   logic [cnt_width(CYC_PER_CM)-1:0] cyc_q;
   logic                             cyc_fim;
   logic                             unused_bits;

   // ------------------------------------------------------------------
   // Counters
   // ------------------------------------------------------------------
   // Trigger width: kept clear while idle, so the first trig_s-high cycle
   // (seen in INICIAL) is already counted. Stops at TRIG_MIN_CYC.
   assign trg_zera  = !((estado == TRIGGER) || ((estado == INICIAL) && trig_s));
   assign trg_conta = trig_s && !trg_fim;

   hcsr04_emulador_contador_m #(.M(TRG_M)) u_trg (
      .clock (clock), .reset (reset), .zera (trg_zera), .conta (trg_conta),
      .q     (trg_q), .fim   (trg_fim)
   );

   // Phase timer restarts on every state change, so q counts cycles spent
   // in the current state.
   assign tmr_zera  = (prox != estado);
   assign tmr_conta = (estado == RAJADA) || (estado == ECO) || (estado == ESPERA);

   hcsr04_emulador_contador_m #(.M(TMR_M)) u_tmr (
      .clock (clock), .reset (reset), .zera (tmr_zera), .conta (tmr_conta),
      .q     (tmr_q), .fim   (tmr_fim)
   );

   // Per-cm cycle counter; each wrap advances cm_cnt by one
   hcsr04_emulador_contador_m #(.M(CYC_PER_CM)) u_cyc (
      .clock (clock), .reset (reset), .zera (estado != ECO), .conta (estado == ECO),
      .q     (cyc_q), .fim   (cyc_fim)
   );

   assign unused_bits = ^{trg_q, tmr_fim, cyc_q};

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   assign em_faixa = (dist_r >= D_MIN) && (dist_r <= D_MAX);

   // In range, ECO ends on the last cycle of the last cm. dist_r >= 2 here,
   // so dist_r-1 never underflows.
`ifdef HCSR04_EMU_TIMEOUT_EN
   assign fim_eco = em_faixa ? (cyc_fim && (cm_cnt == dist_r - 9'd1))
                             : (tmr_q == TOUT_ULT);
`else
   assign fim_eco = cyc_fim && (cm_cnt == dist_r - 9'd1);
`endif

   always_comb begin
      prox = estado;
      case (estado)
         INICIAL: if (trig_s) prox = TRIGGER;
         TRIGGER: if (!trig_s) prox = trg_fim ? RAJADA : INICIAL;
         RAJADA:  if (tmr_q == BURST_ULT) prox = (em_faixa || TIMEOUT_EN) ? ECO : ESPERA;
         ECO:     if (fim_eco) prox = ESPERA;
         ESPERA:  if (tmr_q == HOLD_ULT) prox = INICIAL;
         default: prox = INICIAL;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         trig_m <= 1'b0;
         trig_s <= 1'b0;
         estado <= INICIAL;
         dist_r <= '0;
         cm_cnt <= '0;
         echo   <= 1'b0;
      end else begin
         trig_m <= trigger;
         trig_s <= trig_m;
         estado <= prox;
         // Registered from next state so echo is aligned exactly with ECO
         echo   <= (prox == ECO);
         if ((estado == TRIGGER) && !trig_s && trg_fim)
            dist_r <= distancia_cm;
         if (estado != ECO)
            cm_cnt <= '0;
         else if (cyc_fim)
            cm_cnt <= cm_cnt + 9'd1;
      end
   end

   assign ocupado   = (estado != INICIAL);
   assign db_estado = estado;

endmodule

// File: tb/tb_hcsr04_emulador.sv
module tb_hcsr04_emulador;

   logic       clock = 1'b0;
   logic       reset;
   logic       trigger;
   logic [8:0] distancia_cm;
   logic       echo;
   logic       ocupado;
   logic [3:0] db_estado;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   hcsr04_emulador #(
      .TRIG_MIN_CYC (5),
      .BURST_CYC    (20),
      .CYC_PER_CM   (3),
      .DIST_MIN_CM  (2),
      .DIST_MAX_CM  (400),
      .TIMEOUT_CYC  (1500),
      .HOLDOFF_CYC  (50)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .trigger      (trigger),
      .distancia_cm (distancia_cm),
      .echo         (echo),
      .ocupado      (ocupado),
      .db_estado    (db_estado)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge
   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse(input int n);
      trigger = 1'b1;
      tick(n);
      trigger = 1'b0;
   endtask

   task automatic wait_state(input string tag, input logic [3:0] code, input int budget);
      int n;
      n = 0;
      while (db_estado !== code && n < budget) begin
         tick(1);
         n++;
      end
      chk(tag, db_estado, code);
   endtask

   task automatic run_state(input logic [3:0] code, input int budget, output int n);
      n = 0;
      while (db_estado === code && n < budget) begin
         tick(1);
         n++;
      end
   endtask

   task automatic run_echo(input int budget, output int n);
      n = 0;
      while (echo === 1'b1 && n < budget) begin
         tick(1);
         n++;
      end
   endtask

   // Full cycle after a valid trigger: 20 RAJADA cycles, echo rising on the
   // 21st cycle and lasting echo_len, 50 ESPERA cycles, back to idle.
   task automatic normal(input string tag, input int echo_len);
      int n;
      wait_state({tag, " raj_enter"}, 4'd2, 20);
      run_state(4'd2, 100, n);
      chk({tag, " raj_len"}, n, 20);
      chk({tag, " echo_rise"}, echo, 1);
      chk({tag, " eco_state"}, db_estado, 3);
      run_echo(3000, n);
      chk({tag, " echo_len"}, n, echo_len);
      chk({tag, " espera_state"}, db_estado, 4);
      chk({tag, " espera_ocupado"}, ocupado, 1);
      run_state(4'd4, 200, n);
      chk({tag, " espera_len"}, n, 50);
      chk({tag, " idle_state"}, db_estado, 0);
      chk({tag, " idle_ocupado"}, ocupado, 0);
   endtask

   // Out-of-range path without timeout echo
   task automatic no_echo(input string tag);
      int n;
      wait_state({tag, " raj_enter"}, 4'd2, 20);
      run_state(4'd2, 100, n);
      chk({tag, " raj_len"}, n, 20);
      chk({tag, " espera_state"}, db_estado, 4);
      chk({tag, " echo_low"}, echo, 0);
      run_state(4'd4, 200, n);
      chk({tag, " espera_len"}, n, 50);
      chk({tag, " echo_low_end"}, echo, 0);
      chk({tag, " idle_state"}, db_estado, 0);
   endtask

   initial begin
      int n;
      int bad;
      int runts[2];
      int far[2];
      logic seen1, seen_raj, seen_echo;

      runts = '{3, 4};
      far   = '{500, 1};

      reset        = 1'b1;
      trigger      = 1'b0;
      distancia_cm = 9'd0;
      tick(3);
      chk("reset echo", echo, 0);
      chk("reset ocupado", ocupado, 0);
      chk("reset db_estado", db_estado, 0);
      reset = 1'b0;
      tick(2);

      // 1: nominal 30 cm -> 90 echo cycles
      distancia_cm = 9'd30;
      pulse(10);
      normal("t1", 90);

      // 2: runt pulses are ignored
      foreach (runts[k]) begin
         seen1 = 1'b0; seen_raj = 1'b0; seen_echo = 1'b0;
         trigger = 1'b1;
         for (int i = 0; i < 40; i++) begin
            tick(1);
            if (i == runts[k] - 1) trigger = 1'b0;
            if (db_estado === 4'd1) seen1 = 1'b1;
            if (db_estado === 4'd2) seen_raj = 1'b1;
            if (echo !== 1'b0) seen_echo = 1'b1;
         end
         chk($sformatf("t2 runt%0d trigger_state", runts[k]), seen1, 1);
         chk($sformatf("t2 runt%0d no_rajada", runts[k]), seen_raj, 0);
         chk($sformatf("t2 runt%0d no_echo", runts[k]), seen_echo, 0);
         chk($sformatf("t2 runt%0d idle", runts[k]), db_estado, 0);
         chk($sformatf("t2 runt%0d ocupado", runts[k]), ocupado, 0);
      end

      // 3: out-of-range distances
      foreach (far[k]) begin
         distancia_cm = 9'(far[k]);
         pulse(10);
`ifdef HCSR04_EMU_TIMEOUT_EN
         normal($sformatf("t3 d%0d", far[k]), 1500);
`else
         no_echo($sformatf("t3 d%0d", far[k]));
`endif
      end

      // 4: minimum distance; distance change and trigger during ECO/ESPERA
      distancia_cm = 9'd2;
      pulse(6);
      wait_state("t4 raj_enter", 4'd2, 20);
      run_state(4'd2, 100, n);
      chk("t4 raj_len", n, 20);
      chk("t4 echo_rise", echo, 1);
      distancia_cm = 9'd100;
      trigger = 1'b1;
      run_echo(3000, n);
      chk("t4 echo_len", n, 6);
      tick(5);
      trigger = 1'b0;
      seen_echo = 1'b0; seen_raj = 1'b0;
      for (int i = 0; i < 80; i++) begin
         tick(1);
         if (echo !== 1'b0) seen_echo = 1'b1;
         if (db_estado === 4'd2) seen_raj = 1'b1;
      end
      chk("t4 no_extra_echo", seen_echo, 0);
      chk("t4 no_extra_rajada", seen_raj, 0);
      chk("t4 idle", db_estado, 0);

      // 5: reset during the 10th ECO cycle
      distancia_cm = 9'd30;
      pulse(6);
      wait_state("t5 raj_enter", 4'd2, 20);
      run_state(4'd2, 100, n);
      tick(9);
      chk("t5 mid_eco_state", db_estado, 3);
      chk("t5 mid_eco_echo", echo, 1);
      reset = 1'b1;
      tick(1);
      chk("t5 reset_echo", echo, 0);
      chk("t5 reset_state", db_estado, 0);
      reset = 1'b0;
      tick(2);
      distancia_cm = 9'd5;
      pulse(6);
      normal("t5 after", 15);

      // 6: trigger held high stays in TRIGGER
      distancia_cm = 9'd30;
      trigger = 1'b1;
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         tick(1);
         if (echo !== 1'b0 || db_estado > 4'd1) bad++;
      end
      chk("t6 held_no_echo", bad, 0);
      chk("t6 held_state", db_estado, 1);
      trigger = 1'b0;
      normal("t6", 90);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
